imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory. Takes a byte stream in through a valid/ready handshake
//  and checks a sync byte, a word count and a trailing XOR checksum. Packs the payload little-endian into
//  32-bit words and writes them to IMEM word addresses 0..N-1. Holds the CPU in reset until a load succeeds.

---
 rtl/imem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time IMEM loader.
// Accepts a framed byte stream: sync byte 0xA5, 16-bit little-endian word count,
// the payload, then an XOR checksum of the payload. Payload bytes are packed
// little-endian into 32-bit words, which are written to IMEM addresses 0..N-1.
// The CPU is held in reset until a load ends with a matching checksum.
module imem_loader #(
  parameter int ADDR_W      = 11,
  parameter int MAX_WORDS   = 2048,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     LEN_MAX = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              accept_s;
  logic              counting_s;
  logic              timeout_hit_s;
  logic              last_word_s;
  logic [15:0]       len_full_s;
  logic [7:0]        len_lo_r;
  logic [15:0]       len_r;
  logic [1:0]        bidx_r;
  logic [23:0]       word_r;
  logic [7:0]        csum_r;
  logic [TO_W-1:0]   tcnt_r;
  logic              rx_ready_r;
  logic              im_we_r;
  logic [ADDR_W-1:0] im_waddr_r;
  logic [31:0]       im_wdata_r;
  logic              cpu_rst_r;
  logic              load_done_r;
  logic              load_err_r;
  logic [ADDR_W:0]   words_loaded_r;

  // Running checksum update: one payload byte folded into the XOR sum.
  function automatic logic [7:0] csum_next(input logic [7:0] sum, input logic [7:0] b);
    return sum ^ b;
  endfunction

  assign rx_ready     = rx_ready_r;
  assign im_we        = im_we_r;
  assign im_waddr     = im_waddr_r;
  assign im_wdata     = im_wdata_r;
  assign cpu_rst      = cpu_rst_r;
  assign load_done    = load_done_r;
  assign load_err     = load_err_r;
  assign words_loaded = words_loaded_r;

  assign accept_s      = rx_valid & rx_ready_r;
  assign counting_s    = (state_r == S_LEN_LO) || (state_r == S_LEN_HI) ||
                         (state_r == S_DATA)   || (state_r == S_CSUM);
  assign timeout_hit_s = counting_s && !accept_s && (tcnt_r == TO_LAST);
  assign len_full_s    = {rx_data, len_lo_r};
  assign last_word_s   = ((words_loaded_r + {{ADDR_W{1'b0}}, 1'b1}) == len_r[ADDR_W:0]);

  // Next-state decode for the frame parser.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_SYNC: begin
        if (accept_s && (rx_data == 8'hA5)) state_s = S_LEN_LO;
        else                                state_s = state_r;
      end
      S_LEN_LO: begin
        if (accept_s)           state_s = S_LEN_HI;
        else if (timeout_hit_s) state_s = S_ERR;
        else                    state_s = state_r;
      end
      S_LEN_HI: begin
        if (accept_s) begin
          if ((len_full_s == 16'd0) || (len_full_s > LEN_MAX)) state_s = S_ERR;
          else                                                 state_s = S_DATA;
        end else if (timeout_hit_s) begin
          state_s = S_ERR;
        end else begin
          state_s = state_r;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          if ((bidx_r == 2'd3) && last_word_s) state_s = S_CSUM;
          else                                 state_s = state_r;
        end else if (timeout_hit_s) begin
          state_s = S_ERR;
        end else begin
          state_s = state_r;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (rx_data == csum_r) state_s = S_DONE;
          else                   state_s = S_ERR;
        end else if (timeout_hit_s) begin
          state_s = S_ERR;
        end else begin
          state_s = state_r;
        end
      end
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) state_r <= S_SYNC;
    else       state_r <= state_s;
  end

  // Status outputs, registered from the next state so they track it exactly.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_ready_r  <= 1'b1;
      cpu_rst_r   <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      rx_ready_r  <= (state_s != S_DONE) && (state_s != S_ERR);
      cpu_rst_r   <= (state_s != S_DONE);
      load_done_r <= (state_s == S_DONE);
      load_err_r  <= (state_s == S_ERR);
    end
  end

  // Inter-byte watchdog: cleared by every accepted byte, only runs mid-frame.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tcnt_r <= {TO_W{1'b0}};
    end else if (accept_s || !counting_s) begin
      tcnt_r <= {TO_W{1'b0}};
    end else begin
      tcnt_r <= tcnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // Header capture, payload packing, checksum and IMEM write generation.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      len_lo_r       <= 8'h00;
      len_r          <= 16'h0000;
      bidx_r         <= 2'd0;
      word_r         <= 24'h000000;
      csum_r         <= 8'h00;
      im_we_r        <= 1'b0;
      im_waddr_r     <= {ADDR_W{1'b0}};
      im_wdata_r     <= 32'h00000000;
      words_loaded_r <= {(ADDR_W+1){1'b0}};
    end else begin
      im_we_r <= 1'b0;
      if (accept_s && (state_r == S_LEN_LO)) begin
        len_lo_r <= rx_data;
      end
      if (accept_s && (state_r == S_LEN_HI)) begin
        len_r <= len_full_s;
      end
      if (accept_s && (state_r == S_DATA)) begin
        csum_r <= csum_next(csum_r, rx_data);
        bidx_r <= bidx_r + 2'd1;
        case (bidx_r)
          2'd0:    word_r[7:0]   <= rx_data;
          2'd1:    word_r[15:8]  <= rx_data;
          2'd2:    word_r[23:16] <= rx_data;
          default: begin
            im_we_r        <= 1'b1;
            im_waddr_r     <= words_loaded_r[ADDR_W-1:0];
            im_wdata_r     <= {rx_data, word_r};
            words_loaded_r <= words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the basic
// load, then hand-written sequences for framing, error and reset corner cases.
module tb_imem_loader;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        im_we;
  logic [10:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [11:0] words_loaded;

  int n_pass = 0;
  int n_total = 0;
  int we_double = 0;
  logic prev_we = 1'b0;
  logic [42:0] wq[$];

  imem_loader #(.ADDR_W(11), .MAX_WORDS(2048), .TIMEOUT_CYC(16)) dut (
    .clk_in(clk_in), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk_in = ~clk_in;

  // Record every IMEM write and flag back-to-back strobes.
  always @(negedge clk_in) begin
    if (im_we) wq.push_back({im_waddr, im_wdata});
    if (im_we && prev_we) we_double++;
    prev_we = im_we;
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [59:0] exp;
  } vec_t;

  function automatic logic [59:0] pk(input logic rdy, input logic we, input logic [10:0] a,
                                     input logic [31:0] d, input logic cr, input logic dn,
                                     input logic er, input logic [11:0] w);
    return {rdy, we, a, d, cr, dn, er, w};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset = r; rx_valid = v; rx_data = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    @(negedge clk_in);
    wq.delete();
  endtask

  task automatic send(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) begin
      step(1'b0, 1'b1, bytes[i]);
      if (gap) step(1'b0, 1'b0, 8'hFF);
    end
    rx_valid = 1'b0;
  endtask

  function automatic logic [42:0] wq_at(input int i);
    if (wq.size() > i) return wq[i];
    else return 43'h7FF_FFFF_FFFF;
  endfunction

  task automatic chk_good_writes(input string tag);
    chk({tag, " nwrites"}, 64'(wq.size()), 64'd2);
    chk({tag, " write0"}, 64'(wq_at(0)), 64'({11'd0, 32'h20080005}));
    chk({tag, " write1"}, 64'(wq_at(1)), 64'({11'd1, 32'h00000000}));
  endtask

  logic [7:0] s1[$] = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
  logic [7:0] s_bad[$];
  logic [7:0] s_pre[$];
  vec_t tbl[15];

  initial begin
    // Basic load, one vector per clock; outputs checked after each edge.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[4]  = '{1'b0, 1'b1, 8'h05, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[5]  = '{1'b0, 1'b0, 8'hFF, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[7]  = '{1'b0, 1'b1, 8'h08, pk(1, 0, 11'd0, 32'h0, 1, 0, 0, 12'd0)};
    tbl[8]  = '{1'b0, 1'b1, 8'h20, pk(1, 1, 11'd0, 32'h20080005, 1, 0, 0, 12'd1)};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, pk(1, 0, 11'd0, 32'h20080005, 1, 0, 0, 12'd1)};
    tbl[10] = '{1'b0, 1'b1, 8'h00, pk(1, 0, 11'd0, 32'h20080005, 1, 0, 0, 12'd1)};
    tbl[11] = '{1'b0, 1'b1, 8'h00, pk(1, 0, 11'd0, 32'h20080005, 1, 0, 0, 12'd1)};
    tbl[12] = '{1'b0, 1'b1, 8'h00, pk(1, 1, 11'd1, 32'h00000000, 1, 0, 0, 12'd2)};
    tbl[13] = '{1'b0, 1'b1, 8'h2D, pk(0, 0, 11'd1, 32'h00000000, 0, 1, 0, 12'd2)};
    tbl[14] = '{1'b0, 1'b1, 8'hA5, pk(0, 0, 11'd1, 32'h00000000, 0, 1, 0, 12'd2)};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].data);
      chk($sformatf("vec%0d", i),
          64'(pk(rx_ready, im_we, im_waddr, im_wdata, cpu_rst, load_done, load_err, words_loaded)),
          64'(tbl[i].exp));
    end

    // Junk before the sync byte is discarded.
    do_reset();
    s_pre = '{8'h00, 8'hFF, 8'h5A};
    send(s_pre, 1'b0);
    send(s1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk_good_writes("t2");
    chk("t2 done", 64'({load_done, load_err, cpu_rst}), 64'({1'b1, 1'b0, 1'b0}));
    chk("t2 words", 64'(words_loaded), 64'd2);

    // Bad checksum: writes still happen, then a sticky error.
    do_reset();
    s_bad = s1;
    s_bad[11] = 8'h2C;
    send(s_bad, 1'b0);
    chk_good_writes("t3");
    chk("t3 status", 64'({load_err, cpu_rst, rx_ready, load_done}),
        64'({1'b1, 1'b1, 1'b0, 1'b0}));
    step(1'b0, 1'b1, 8'hA5);
    chk("t3 err held", 64'({load_err, load_done, rx_ready}), 64'({1'b1, 1'b0, 1'b0}));

    // Zero length, oversize length, and the largest legal length.
    do_reset();
    send('{8'hA5, 8'h00, 8'h00}, 1'b0);
    chk("t4 len0 err", 64'({load_err, cpu_rst, load_done}), 64'({1'b1, 1'b1, 1'b0}));
    chk("t4 len0 nwrites", 64'(wq.size()), 64'd0);
    do_reset();
    send('{8'hA5, 8'h01, 8'h08}, 1'b0);
    chk("t4 len2049 err", 64'({load_err, rx_ready}), 64'({1'b1, 1'b0}));
    chk("t4 len2049 nwrites", 64'(wq.size()), 64'd0);
    do_reset();
    send('{8'hA5, 8'h00, 8'h08}, 1'b0);
    chk("t4 len2048 ok", 64'({load_err, rx_ready}), 64'({1'b0, 1'b1}));

    // Timeout: counter restarts on each accepted byte, fires on 16th idle cycle.
    do_reset();
    send('{8'hA5, 8'h01, 8'h00, 8'h11}, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00);
    chk("t5 no early timeout", 64'(load_err), 64'd0);
    send('{8'h22}, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00);
    chk("t5 15 idle", 64'(load_err), 64'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("t5 16 idle", 64'({load_err, cpu_rst, rx_ready}), 64'({1'b1, 1'b1, 1'b0}));
    chk("t5 nwrites", 64'(wq.size()), 64'd0);

    // rx_valid toggling every cycle.
    do_reset();
    send(s1, 1'b1);
    chk_good_writes("t6");
    chk("t6 done", 64'({load_done, cpu_rst, words_loaded}), 64'({1'b1, 1'b0, 12'd2}));

    // Reset part-way through the payload, then a fresh load restarts at 0.
    do_reset();
    send('{8'hA5, 8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00}, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    chk("t6b reset", 64'({words_loaded, load_done, load_err, cpu_rst, rx_ready, im_we, im_waddr, im_wdata}),
        64'({12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 32'h0}));
    do_reset();
    send(s1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk_good_writes("t6b");
    chk("t6b done", 64'({load_done, load_err, words_loaded}), 64'({1'b1, 1'b0, 12'd2}));

    chk("no back-to-back im_we", 64'(we_double), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
